// File: rtl/data_link_pkg.sv
// Shared types and frame geometry for the SWIPT telemetry/feedback link.
//
// Build option: DATA_PARITY_EN
//   defined   - every 16-bit word carries a trailing even-parity bit, on TX and on RX.
//   undefined - plain 16-bit words.
//
// Contents: FSM state enum, SYNC_BYTE, WORD_COUNT, derived frame lengths and the helper that
// turns a telemetry word into its on-air slot (word plus optional parity).
package data_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAL,
        TX,
        RX_WAIT,
        RX,
        DECIDE
    } state_e;

    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam int unsigned WORD_COUNT = 9;
    localparam int unsigned WORD_W     = 16;

`ifdef DATA_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

    localparam int unsigned SLOT_W    = WORD_W + PAR_BITS;
    localparam int unsigned PAYLOAD_W = WORD_COUNT * SLOT_W;
    localparam int unsigned TX_BITS   = 8 + PAYLOAD_W;
    localparam int unsigned RX_BITS   = SLOT_W;

    // Word as sent on the wire: MSB first, parity (if enabled) last.
    function automatic logic [SLOT_W-1:0] make_slot(input logic [WORD_W-1:0] w);
`ifdef DATA_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

endpackage

// File: rtl/data_bit_timer.sv
// Bit-period timer for the data link.
//
// Counts 0 .. BIT_CYCLES-1 repeatedly; restart forces the count back to 0 on the next cycle.
//   clk      in  system clock
//   nrst     in  asynchronous active-high reset
//   restart  in  restart the bit period (state entry, start-bit detection)
//   bit_end  out high on the last cycle of a bit period
//   mid_bit  out high BIT_CYCLES/2 cycles into a bit period
module data_bit_timer #(
    parameter int unsigned BIT_CYCLES = 100
) (
    input  logic clk,
    input  logic nrst,
    input  logic restart,
    output logic bit_end,
    output logic mid_bit
);

    localparam int unsigned CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MID  = CNT_W'(BIT_CYCLES / 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = (cnt_q == LAST);
    assign mid_bit = (cnt_q == MID);

endmodule

// File: rtl/data_link.sv
// SWIPT telemetry/feedback link (program phase 2'b11).
//
// Each loop: CAL (request mean-current refresh) -> TX (SYNC + nine telemetry words) ->
// RX_WAIT (look for start bit) -> RX (16-bit reply) -> DECIDE (duty-step request) -> CAL.
// Build option DATA_PARITY_EN adds an even-parity bit per word on TX and RX.
//
// Ports
//   clk, nrst                 clock, asynchronous active-high reset
//   swiptAlive, program_phase link enable and system phase; run = swiptAlive && phase==2'b11
//   ADC, meanCurrent          12-bit coil current and its average (RX slicing threshold)
//   SWIPT_P_TX .. COMMS_FLIGHT_TIME  telemetry words, sent in port order
//   RECEIVED_EFF, RECEIVED_POWER_RX  last valid reply bytes
//   read, write, dout         RX window, TX window, TX serial bit
//   l_rdy, l_up_down          one-cycle duty-step request (1 = lower duty)
//   getMeanCurrent            high during CAL
module data_link
    import data_link_pkg::*;
#(
    parameter int unsigned BIT_CYCLES   = 100,
    parameter int unsigned CAL_CYCLES   = 1000,
    parameter int unsigned RX_TIMEOUT   = 20000,
    parameter int unsigned HYST         = 16,
    parameter int unsigned POWER_TARGET = 128
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        swiptAlive,
    input  logic [1:0]  program_phase,
    input  logic [11:0] ADC,
    input  logic [11:0] meanCurrent,
    input  logic [15:0] SWIPT_P_TX,
    input  logic [15:0] SWIPT_DUTY,
    input  logic [15:0] SWIPT_FREQ,
    input  logic [15:0] SWIPT_ASCII,
    input  logic [15:0] ANC_MAX_HEIGHT,
    input  logic [15:0] ANC_MIN_HEIGHT,
    input  logic [15:0] COMMS_TRAJECT,
    input  logic [15:0] COMMS_QR_CODES,
    input  logic [15:0] COMMS_FLIGHT_TIME,
    output logic [7:0]  RECEIVED_EFF,
    output logic [7:0]  RECEIVED_POWER_RX,
    output logic        read,
    output logic        write,
    output logic        dout,
    output logic        l_rdy,
    output logic        l_up_down,
    output logic        getMeanCurrent
);

    localparam int unsigned WAIT_MAX = (CAL_CYCLES > RX_TIMEOUT) ? CAL_CYCLES : RX_TIMEOUT;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int unsigned TXI_W    = $clog2(TX_BITS + 1);
    localparam int unsigned RXI_W    = $clog2(RX_BITS + 1);
    localparam logic [7:0]  PWR_TGT  = 8'(POWER_TARGET);

    state_e               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d, wait_inc;
    logic [TX_BITS-1:0]   tx_sr_q, tx_sr_d;
    logic [TXI_W-1:0]     tx_idx_q, tx_idx_d;
    logic [RX_BITS-1:0]   rx_sr_q, rx_sr_d, rx_next;
    logic [RXI_W-1:0]     rx_idx_q, rx_idx_d;
    logic                 start_seen_q, start_seen_d;
    logic [7:0]           eff_q, eff_d, pwr_q, pwr_d;

    logic                 run;
    logic [12:0]          start_thr;
    logic                 above_start, above_mean;
    logic [WORD_W-1:0]    rx_word;
    logic                 rx_parity_ok;
    logic [PAYLOAD_W-1:0] payload;
    logic                 timer_restart, start_detect;
    logic                 bit_end, mid_bit;

    assign run         = swiptAlive && (program_phase == 2'b11);
    // 13-bit sum so a threshold near full scale cannot wrap to a small value.
    assign start_thr   = {1'b0, meanCurrent} + 13'(HYST);
    assign above_start = ({1'b0, ADC} > start_thr);
    assign above_mean  = (ADC > meanCurrent);
    assign rx_next     = {rx_sr_q[RX_BITS-2:0], above_mean};
    assign rx_word     = rx_sr_q[RX_BITS-1 -: WORD_W];
    assign wait_inc    = (&wait_q) ? wait_q : wait_q + 1'b1;

`ifdef DATA_PARITY_EN
    assign rx_parity_ok = ~^rx_next;
`else
    assign rx_parity_ok = 1'b1;
`endif

    assign payload = {make_slot(SWIPT_P_TX),     make_slot(SWIPT_DUTY),
                      make_slot(SWIPT_FREQ),     make_slot(SWIPT_ASCII),
                      make_slot(ANC_MAX_HEIGHT), make_slot(ANC_MIN_HEIGHT),
                      make_slot(COMMS_TRAJECT),  make_slot(COMMS_QR_CODES),
                      make_slot(COMMS_FLIGHT_TIME)};

    data_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk     (clk),
        .nrst    (nrst),
        .restart (timer_restart),
        .bit_end (bit_end),
        .mid_bit (mid_bit)
    );

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        tx_sr_d      = tx_sr_q;
        tx_idx_d     = tx_idx_q;
        rx_sr_d      = rx_sr_q;
        rx_idx_d     = rx_idx_q;
        start_seen_d = start_seen_q;
        eff_d        = eff_q;
        pwr_d        = pwr_q;
        start_detect = 1'b0;

        if (!run) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = CAL;

                CAL: begin
                    if (wait_q >= WAIT_W'(CAL_CYCLES - 1)) begin
                        state_d  = TX;
                        tx_sr_d  = {SYNC_BYTE, payload};
                        tx_idx_d = '0;
                    end else begin
                        wait_d = wait_inc;
                    end
                end

                TX: begin
                    if (bit_end) begin
                        if (tx_idx_q >= TXI_W'(TX_BITS - 1)) begin
                            state_d = RX_WAIT;
                        end else begin
                            tx_sr_d  = tx_sr_q << 1;
                            tx_idx_d = tx_idx_q + 1'b1;
                        end
                    end
                end

                RX_WAIT: begin
                    if (!start_seen_q) begin
                        if (wait_q >= WAIT_W'(RX_TIMEOUT - 1)) begin
                            state_d = CAL;
                        end else begin
                            wait_d = wait_inc;
                            if (above_start) begin
                                start_seen_d = 1'b1;
                                start_detect = 1'b1;
                            end
                        end
                    end else begin
                        wait_d = wait_inc;
                        if (mid_bit) begin
                            // Low at mid-point: glitch, go back to hunting.
                            start_seen_d = 1'b0;
                            if (above_start) begin
                                state_d  = RX;
                                rx_idx_d = '0;
                            end
                        end
                    end
                end

                // Entered at mid-start-bit, so each bit_end falls mid-way through a data bit.
                RX: begin
                    if (bit_end) begin
                        rx_sr_d = rx_next;
                        if (rx_idx_q >= RXI_W'(RX_BITS - 1)) begin
                            state_d = rx_parity_ok ? DECIDE : CAL;
                        end else begin
                            rx_idx_d = rx_idx_q + 1'b1;
                        end
                    end
                end

                DECIDE: begin
                    eff_d   = rx_word[15:8];
                    pwr_d   = rx_word[7:0];
                    state_d = CAL;
                end

                default: state_d = IDLE;
            endcase
        end

        timer_restart = start_detect;
        if (state_d != state_q) begin
            wait_d        = '0;
            start_seen_d  = 1'b0;
            timer_restart = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            tx_sr_q      <= '0;
            tx_idx_q     <= '0;
            rx_sr_q      <= '0;
            rx_idx_q     <= '0;
            start_seen_q <= 1'b0;
            eff_q        <= '0;
            pwr_q        <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            tx_sr_q      <= tx_sr_d;
            tx_idx_q     <= tx_idx_d;
            rx_sr_q      <= rx_sr_d;
            rx_idx_q     <= rx_idx_d;
            start_seen_q <= start_seen_d;
            eff_q        <= eff_d;
            pwr_q        <= pwr_d;
        end
    end

    // Gated by run so a phase change silences the link in the same cycle.
    assign read              = run && ((state_q == RX_WAIT) || (state_q == RX));
    assign write             = run && (state_q == TX);
    assign dout              = write && tx_sr_q[TX_BITS-1];
    assign getMeanCurrent    = run && (state_q == CAL);
    assign l_rdy             = run && (state_q == DECIDE);
    assign l_up_down         = l_rdy && (rx_word[7:0] >= PWR_TGT);
    assign RECEIVED_EFF      = eff_q;
    assign RECEIVED_POWER_RX = pwr_q;

endmodule

// File: tb/tb_data_link.sv
module tb_data_link;

    localparam int BIT  = 20;
    localparam int CALC = 50;
    localparam int TOUT = 600;
    localparam int HYS  = 16;
    localparam int PTGT = 128;

    logic        clk = 1'b0;
    logic        nrst;
    logic        swiptAlive;
    logic [1:0]  program_phase;
    logic [11:0] ADC;
    logic [11:0] meanCurrent;
    logic [15:0] words [9];
    logic [7:0]  RECEIVED_EFF, RECEIVED_POWER_RX;
    logic        read, write, dout, l_rdy, l_up_down, getMeanCurrent;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_eff = 8'h00;
    logic [7:0] exp_pwr = 8'h00;
    bit exp_bits[$];

    always #5 clk = ~clk;

    data_link #(
        .BIT_CYCLES   (BIT),
        .CAL_CYCLES   (CALC),
        .RX_TIMEOUT   (TOUT),
        .HYST         (HYS),
        .POWER_TARGET (PTGT)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .swiptAlive        (swiptAlive),
        .program_phase     (program_phase),
        .ADC               (ADC),
        .meanCurrent       (meanCurrent),
        .SWIPT_P_TX        (words[0]),
        .SWIPT_DUTY        (words[1]),
        .SWIPT_FREQ        (words[2]),
        .SWIPT_ASCII       (words[3]),
        .ANC_MAX_HEIGHT    (words[4]),
        .ANC_MIN_HEIGHT    (words[5]),
        .COMMS_TRAJECT     (words[6]),
        .COMMS_QR_CODES    (words[7]),
        .COMMS_FLIGHT_TIME (words[8]),
        .RECEIVED_EFF      (RECEIVED_EFF),
        .RECEIVED_POWER_RX (RECEIVED_POWER_RX),
        .read              (read),
        .write             (write),
        .dout              (dout),
        .l_rdy             (l_rdy),
        .l_up_down         (l_up_down),
        .getMeanCurrent    (getMeanCurrent)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit parity_of(input logic [15:0] w);
        return ($countones(w) % 2) != 0;
    endfunction

    // Expected serial stream: sync byte, then each word MSB first (plus parity if built in).
    task automatic build_tx();
        logic [7:0] sync;
        sync = 8'hA5;
        exp_bits.delete();
        for (int b = 7; b >= 0; b--) exp_bits.push_back(sync[b]);
        for (int w = 0; w < 9; w++) begin
            for (int b = 15; b >= 0; b--) exp_bits.push_back(words[w][b]);
`ifdef DATA_PARITY_EN
            exp_bits.push_back(parity_of(words[w]));
`endif
        end
    endtask

    // Measures one CAL window; returns at the first negedge after it.
    task automatic do_cal(input string tag);
        int wt;
        int cnt;
        wt = 0;
        while (getMeanCurrent !== 1'b1 && wt < 4 * CALC) begin
            @(negedge clk);
            wt++;
        end
        cnt = 0;
        while (getMeanCurrent === 1'b1 && cnt < 4 * CALC) begin
            cnt++;
            @(negedge clk);
        end
        check({tag, "_cal_len"}, cnt, CALC);
    endtask

    task automatic do_tx(input string tag);
        int wcnt;
        int ok;
        build_tx();
        wcnt = 0;
        for (int i = 0; i < exp_bits.size(); i++) begin
            ok = 0;
            for (int c = 0; c < BIT; c++) begin
                if (write === 1'b1) wcnt++;
                if (dout === exp_bits[i]) ok++;
                @(negedge clk);
            end
            check($sformatf("%s_tx_bit%0d", tag, i), ok, BIT);
        end
        check({tag, "_tx_write_cycles"}, wcnt, exp_bits.size() * BIT);
        check({tag, "_tx_end_write"}, write, 0);
        check({tag, "_tx_end_read"}, read, 1);
    endtask

    // Drives a load-modulated reply and checks the decision. abort_off >= 0 drops the
    // phase that many cycles into the data bits.
    task automatic do_reply(input string tag, input logic [15:0] word, input bit glitch,
                            input bit bad_par, input int abort_off);
        logic [11:0] hi, lo, bnd;
        logic [11:0] wave[$];
        int rdy_cnt, abort_at, n;
        logic ud;
        bit valid, p;
        hi  = meanCurrent + 12'd200;
        lo  = meanCurrent - 12'd200;
        bnd = meanCurrent + 12'(HYS);
        n = $urandom_range(0, 3 * BIT);
        for (int i = 0; i < n; i++) wave.push_back(($urandom_range(0, 1) != 0) ? lo : bnd);
        if (glitch) begin
            n = $urandom_range(1, BIT / 2 - 2);
            for (int i = 0; i < n; i++) wave.push_back(hi);
            for (int i = 0; i < 2 * BIT; i++) wave.push_back(lo);
        end
        for (int i = 0; i < BIT; i++) wave.push_back(hi);
        abort_at = (abort_off >= 0) ? wave.size() + abort_off : -1;
        for (int b = 15; b >= 0; b--)
            for (int i = 0; i < BIT; i++) wave.push_back(word[b] ? hi : lo);
`ifdef DATA_PARITY_EN
        p = parity_of(word) ^ bad_par;
        for (int i = 0; i < BIT; i++) wave.push_back(p ? hi : lo);
`else
        p = bad_par;
`endif
        for (int i = 0; i < 3 * BIT; i++) wave.push_back(lo);
        valid = !p && (abort_off < 0);
`ifdef DATA_PARITY_EN
        valid = !bad_par && (abort_off < 0);
`endif
        rdy_cnt = 0;
        ud = 1'b0;
        for (int k = 0; k < wave.size(); k++) begin
            ADC = wave[k];
            if (k == abort_at) begin
                program_phase = 2'b10;
                @(negedge clk);
                check({tag, "_abort_read"}, read, 0);
                check({tag, "_abort_gmc"}, getMeanCurrent, 0);
                for (int i = 0; i < 2 * BIT; i++) begin
                    if (l_rdy === 1'b1) rdy_cnt++;
                    @(negedge clk);
                end
                program_phase = 2'b11;
                break;
            end
            @(negedge clk);
            if (l_rdy === 1'b1) begin
                rdy_cnt++;
                ud = l_up_down;
            end
            if (getMeanCurrent === 1'b1) break;
        end
        ADC = lo;
        if (valid) begin
            exp_eff = word[15:8];
            exp_pwr = word[7:0];
            check({tag, "_rdy_pulses"}, rdy_cnt, 1);
            check({tag, "_up_down"}, ud, (word[7:0] >= 8'(PTGT)) ? 1 : 0);
        end else begin
            check({tag, "_rdy_pulses"}, rdy_cnt, 0);
        end
        check({tag, "_eff"}, RECEIVED_EFF, exp_eff);
        check({tag, "_pwr"}, RECEIVED_POWER_RX, exp_pwr);
    endtask

    task automatic rand_words();
        for (int i = 0; i < 9; i++) words[i] = 16'($urandom);
    endtask

    initial begin
        int cnt, rdy_cnt;
        logic [15:0] rw;
        nrst          = 1'b1;
        swiptAlive    = 1'b1;
        program_phase = 2'b11;
        meanCurrent   = 12'd2000;
        ADC           = 12'd1800;
        for (int i = 0; i < 9; i++) words[i] = 16'h9999;

        repeat (3) @(negedge clk);
        check("reset_ctl", {read, write, dout, l_rdy, l_up_down, getMeanCurrent}, 0);
        check("reset_rx", {RECEIVED_EFF, RECEIVED_POWER_RX}, 0);
        nrst = 1'b0;

        // Reset pulse in the middle of TX.
        cnt = 0;
        while (write !== 1'b1 && cnt < 4 * CALC) begin
            @(negedge clk);
            cnt++;
        end
        repeat (37) @(negedge clk);
        check("pre_reset_write", write, 1);
        nrst = 1'b1;
        #1;
        check("midtx_reset_ctl", {read, write, dout, l_rdy, l_up_down, getMeanCurrent}, 0);
        @(negedge clk);
        nrst = 1'b0;

        // Frame A: 16'h9999 words, reply 16'h50C8.
        do_cal("A");
        do_tx("A");
        do_reply("A", 16'h50C8, 1'b0, 1'b0, -1);

        // Frame B: low power reply behind a start glitch.
        rand_words();
        do_cal("B");
        do_tx("B");
        rw = {8'($urandom), 8'h40};
        do_reply("B", rw, 1'b1, 1'b0, -1);

        // Randomised frames.
        for (int f = 0; f < 4; f++) begin
            rand_words();
            meanCurrent = 12'($urandom_range(600, 3400));
            do_cal($sformatf("R%0d", f));
            do_tx($sformatf("R%0d", f));
            do_reply($sformatf("R%0d", f), 16'($urandom), ($urandom_range(0, 1) != 0), 1'b0, -1);
        end

        // Timeout: threshold near full scale must not wrap, so ADC=4095 is never a start.
        rand_words();
        do_cal("T");
        do_tx("T");
        meanCurrent = 12'd4090;
        ADC         = 12'd4095;
        cnt = 0;
        rdy_cnt = 0;
        while (read === 1'b1 && cnt < TOUT + 4 * BIT) begin
            cnt++;
            if (l_rdy === 1'b1) rdy_cnt++;
            @(negedge clk);
        end
        check("T_timeout_len", cnt, TOUT);
        check("T_rdy_pulses", rdy_cnt, 0);
        check("T_gmc", getMeanCurrent, 1);
        check("T_eff", RECEIVED_EFF, exp_eff);
        check("T_pwr", RECEIVED_POWER_RX, exp_pwr);
        meanCurrent = 12'd2000;
        ADC         = 12'd1800;

        // Phase drop during RX data.
        do_cal("X");
        do_tx("X");
        do_reply("X", 16'h1234, 1'b0, 1'b0, 5 * BIT + 3);

`ifdef DATA_PARITY_EN
        do_cal("P");
        do_tx("P");
        do_reply("P", 16'hA1F0, 1'b0, 1'b1, -1);
`endif

        // Recovery frame.
        rand_words();
        do_cal("Z");
        do_tx("Z");
        do_reply("Z", 16'h7F80, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
